// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: issues 4-word bursts to main memory, buffers the returned words
// in a prefetch FIFO and hands them to decode. Optional counters are enabled by FETCH_PERF_EN.
module fetch_prefetch_unit #(
  parameter int                        ADDRESS_SIZE  = 32,
  parameter int                        DATA_SIZE     = 32,
  parameter logic [ADDRESS_SIZE-1:0]   START_ADDRESS = 32'h80020000,
  parameter int                        FIFO_DEPTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect,
  input  logic [ADDRESS_SIZE-1:0] redirect_pc,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [1:0]              mem_acc_size,
  output logic                    mem_en,
  output logic                    mem_wren,
  input  logic                    mem_busy,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  output logic [DATA_SIZE-1:0]    insn,
  output logic [ADDRESS_SIZE-1:0] insn_pc,
  output logic                    insn_valid,
  input  logic                    insn_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             perf_bursts,
  output logic [31:0]             perf_squashed
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BURST, DRAIN} state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [1:0]              r_beat;
  logic [ADDRESS_SIZE-1:0] r_fetchPc;
  logic [ADDRESS_SIZE-1:0] r_memAddr;

  logic [DATA_SIZE-1:0]    r_dataMem [FIFO_DEPTH];
  logic [ADDRESS_SIZE-1:0] r_pcMem   [FIFO_DEPTH];
  logic [PW-1:0]           r_wrPtr;
  logic [PW-1:0]           r_rdPtr;
  logic [CW-1:0]           r_count;

  logic                    w_issue;
  logic                    w_push;
  logic                    w_squash;
  logic                    w_pop;
  logic                    w_room;
  logic                    w_lastBeat;
  logic [ADDRESS_SIZE-1:0] w_redirectPc;
  logic [ADDRESS_SIZE-1:0] w_beatPc;

  assign w_lastBeat   = (r_beat == 2'd3);
  assign w_room       = (r_count <= CW'(FIFO_DEPTH - 4));
  assign w_redirectPc = redirect_pc & ~ADDRESS_SIZE'(3);
  assign w_beatPc     = r_memAddr + ADDRESS_SIZE'({r_beat, 2'b00});
  assign w_pop        = insn_valid && insn_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // A burst cannot be aborted, so a redirect mid-burst must still wait out every beat.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!redirect && w_room && !mem_busy) w_nextState = ISSUE;
      ISSUE:   w_nextState = redirect ? DRAIN : BURST;
      BURST:   if (w_lastBeat) w_nextState = IDLE;
               else if (redirect) w_nextState = DRAIN;
      DRAIN:   if (w_lastBeat) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_issue  = 1'b0;
    w_push   = 1'b0;
    w_squash = 1'b0;
    case (r_state)
      ISSUE: w_issue = 1'b1;
      BURST: begin
        w_push   = !redirect;
        w_squash = redirect;
      end
      DRAIN: w_squash = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat    <= 2'd0;
      r_fetchPc <= START_ADDRESS;
      r_memAddr <= START_ADDRESS;
    end else begin
      if (r_state == ISSUE)
        r_beat <= 2'd0;
      else if (r_state == BURST || r_state == DRAIN)
        r_beat <= r_beat + 2'd1;

      // Latching the burst address keeps mem_addr stable even if fetch_pc is redirected mid-burst.
      if (r_state == IDLE && w_nextState == ISSUE)
        r_memAddr <= r_fetchPc;

      if (redirect)
        r_fetchPc <= w_redirectPc;
      else if (r_state == BURST && w_lastBeat)
        r_fetchPc <= r_memAddr + ADDRESS_SIZE'(16);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dataMem[r_wrPtr] <= mem_d_out;
      r_pcMem[r_wrPtr]   <= w_beatPc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(w_push && !w_pop && r_count == CW'(FIFO_DEPTH)));
  end

  assign insn_valid   = (r_count != '0);
  assign insn         = insn_valid ? r_dataMem[r_rdPtr] : '0;
  assign insn_pc      = insn_valid ? r_pcMem[r_rdPtr]   : '0;
  assign mem_addr     = r_memAddr;
  assign mem_en       = w_issue;
  assign mem_acc_size = 2'b01;
  assign mem_wren     = 1'b0;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perfBursts;
  logic [31:0] r_perfSquashed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perfBursts   <= '0;
      r_perfSquashed <= '0;
    end else begin
      if (w_issue && r_perfBursts != '1)    r_perfBursts   <= r_perfBursts + 32'd1;
      if (w_squash && r_perfSquashed != '1) r_perfSquashed <= r_perfSquashed + 32'd1;
    end
  end

  assign perf_bursts   = r_perfBursts;
  assign perf_squashed = r_perfSquashed;
`endif

endmodule
